// File: rtl/dmem_guard.sv
// -----------------------------------------------------------------------------
// dmem_guard
//
// Access guard between the control/ALU stage and the data memory of the
// single-cycle MIPS datapath. Every active load/store is checked for address
// overflow against MEM_BYTES and, optionally, for natural alignment. Violating
// accesses never reach memory. The first fault is captured and the guard halts
// all memory traffic until err_clr_i. A saturating counter tracks how many
// faults have entered the halt state.
//
// State table:
//   state    | meaning
//   ST_RUN   | normal operation, clean accesses pass to memory
//   ST_FAULT | halted after a fault, all strobes blocked, capture held
//
// Ports:
//   clk_i                   clock, rising edge
//   rst_i                   synchronous active-high reset
//   addr_i                  byte address of the access
//   num_i                   access size: 11 word, 10 half, 01 byte, 00 invalid
//   mem_read_i/mem_write_i  load/store requests
//   err_clr_i               clears halt and fault capture (FAULT state only)
//   mem_read_o/mem_write_o  gated strobes to memory
//   error_addressOverflow_o overflow this cycle (combinational)
//   error_dataMisalign_o    misalignment this cycle (combinational)
//   halt_o                  registered, high in ST_FAULT
//   fault_addr_o/type_o/num_o  capture of the first fault ({ovf, mis} for type)
//   err_count_o             saturating fault counter, cleared by rst_i only
// -----------------------------------------------------------------------------
module dmem_guard #(
    parameter int ADDR_W      = 32,
    parameter int MEM_BYTES   = 1024,
    parameter bit CHECK_ALIGN = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        num_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              err_clr_i,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              error_addressOverflow_o,
    output logic              error_dataMisalign_o,
    output logic              halt_o,
    output logic [ADDR_W-1:0] fault_addr_o,
    output logic [1:0]        fault_type_o,
    output logic [1:0]        fault_num_o,
    output logic [CNT_W-1:0]  err_count_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    // One extra bit so that addr + size - 1 cannot wrap below the limit.
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] ONE_EXT = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic [1:0]          fault_type_q, fault_type_d;
    logic [1:0]          fault_num_q,  fault_num_d;
    logic [CNT_W-1:0]    err_count_q,  err_count_d;

    logic                access_active;
    logic                num_invalid;
    logic [2:0]          size_bytes;
    logic                misalign_raw;
    logic [ADDR_W:0]     addr_ext;
    logic [ADDR_W:0]     last_ext;
    logic                ovf;
    logic                mis;
    logic                violation;

    // ------------------------------------------------------------------
    // Combinational checks
    // ------------------------------------------------------------------
    always_comb begin
        size_bytes   = 3'd0;
        misalign_raw = 1'b0;
        case (num_i)
            2'b11: begin
                size_bytes   = 3'd4;
                misalign_raw = (addr_i[1:0] != 2'b00);
            end
            2'b10: begin
                size_bytes   = 3'd2;
                misalign_raw = addr_i[0];
            end
            2'b01: begin
                size_bytes   = 3'd1;
                misalign_raw = 1'b0;
            end
            default: begin
                size_bytes   = 3'd0;
                misalign_raw = 1'b0;
            end
        endcase
    end

    assign access_active = mem_read_i | mem_write_i;
    assign num_invalid   = (num_i == 2'b00);
    assign addr_ext      = {1'b0, addr_i};
    // For an invalid size the last byte is meaningless; the access faults anyway.
    assign last_ext      = addr_ext + (ADDR_W+1)'(size_bytes) - ONE_EXT;

    assign ovf = access_active &
                 (num_invalid | (addr_ext >= MEM_LIM) | (last_ext >= MEM_LIM));

    // With alignment checking disabled the misalign flag is held low even
    // for an invalid size; the overflow flag alone still makes it a fault.
    assign mis = (CHECK_ALIGN == 1'b1) ? (access_active & (num_invalid | misalign_raw))
                                       : 1'b0;

    assign violation = ovf | mis;

    assign error_addressOverflow_o = ovf;
    assign error_dataMisalign_o    = mis;

    // Strobes pass only for a clean access while running.
    assign mem_read_o  = mem_read_i  & ~violation & (state_q == ST_RUN);
    assign mem_write_o = mem_write_i & ~violation & (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Fault-halt FSM: next state, capture and counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fault_addr_d = fault_addr_q;
        fault_type_d = fault_type_q;
        fault_num_d  = fault_num_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_RUN: begin
                if (violation) begin
                    state_d      = ST_FAULT;
                    fault_addr_d = addr_i;
                    fault_type_d = {ovf, mis};
                    fault_num_d  = num_i;
                    if (err_count_q != {CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                // Clear wins over a simultaneous new violation.
                if (err_clr_i) begin
                    state_d      = ST_RUN;
                    fault_addr_d = '0;
                    fault_type_d = '0;
                    fault_num_d  = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            fault_addr_q <= '0;
            fault_type_q <= '0;
            fault_num_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            fault_addr_q <= fault_addr_d;
            fault_type_q <= fault_type_d;
            fault_num_q  <= fault_num_d;
            err_count_q  <= err_count_d;
        end
    end

    assign halt_o       = (state_q == ST_FAULT);
    assign fault_addr_o = fault_addr_q;
    assign fault_type_o = fault_type_q;
    assign fault_num_o  = fault_num_q;
    assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_dmem_guard.sv
// -----------------------------------------------------------------------------
// tb_dmem_guard
//
// Directed bench for dmem_guard. Three instances share one stimulus stream:
//   u_def  default parameters
//   u_nal  CHECK_ALIGN = 0
//   u_c2   CNT_W = 2 (counter saturation)
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the following edge.
// -----------------------------------------------------------------------------
module tb_dmem_guard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [1:0]  num_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        err_clr_i;

    logic        d_rd, d_wr, d_ovf, d_mis, d_halt;
    logic [31:0] d_faddr;
    logic [1:0]  d_ftype, d_fnum;
    logic [7:0]  d_cnt;

    logic        n_rd, n_wr, n_ovf, n_mis, n_halt;
    logic [31:0] n_faddr;
    logic [1:0]  n_ftype, n_fnum;
    logic [7:0]  n_cnt;

    logic        c_rd, c_wr, c_ovf, c_mis, c_halt;
    logic [31:0] c_faddr;
    logic [1:0]  c_ftype, c_fnum;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dmem_guard u_def (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .num_i(num_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .err_clr_i(err_clr_i),
        .mem_read_o(d_rd), .mem_write_o(d_wr),
        .error_addressOverflow_o(d_ovf), .error_dataMisalign_o(d_mis),
        .halt_o(d_halt), .fault_addr_o(d_faddr), .fault_type_o(d_ftype),
        .fault_num_o(d_fnum), .err_count_o(d_cnt)
    );

    dmem_guard #(.CHECK_ALIGN(1'b0)) u_nal (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .num_i(num_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .err_clr_i(err_clr_i),
        .mem_read_o(n_rd), .mem_write_o(n_wr),
        .error_addressOverflow_o(n_ovf), .error_dataMisalign_o(n_mis),
        .halt_o(n_halt), .fault_addr_o(n_faddr), .fault_type_o(n_ftype),
        .fault_num_o(n_fnum), .err_count_o(n_cnt)
    );

    dmem_guard #(.CNT_W(2)) u_c2 (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .num_i(num_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .err_clr_i(err_clr_i),
        .mem_read_o(c_rd), .mem_write_o(c_wr),
        .error_addressOverflow_o(c_ovf), .error_dataMisalign_o(c_mis),
        .halt_o(c_halt), .fault_addr_o(c_faddr), .fault_type_o(c_ftype),
        .fault_num_o(c_fnum), .err_count_o(c_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic apply(input logic rd, input logic wr, input logic [1:0] num,
                         input logic [31:0] addr, input logic clr);
        mem_read_i  = rd;
        mem_write_i = wr;
        num_i       = num;
        addr_i      = addr;
        err_clr_i   = clr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    logic [1:0] exp_cnt;

    initial begin
        rst_i = 1'b1;
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        tick;
        tick;
        check("rst_halt",  {63'd0, d_halt}, 64'd0);
        check("rst_faddr", {32'd0, d_faddr}, 64'd0);
        check("rst_cnt",   {56'd0, d_cnt}, 64'd0);
        check("idle_ovf",  {63'd0, d_ovf}, 64'd0);
        rst_i = 1'b0;

        // Word read at 1020 is the last legal word.
        apply(1'b1, 1'b0, 2'b11, 32'd1020, 1'b0);
        check("w1020_rd",  {63'd0, d_rd}, 64'd1);
        check("w1020_ovf", {63'd0, d_ovf}, 64'd0);
        check("w1020_mis", {63'd0, d_mis}, 64'd0);
        tick;
        check("w1020_halt", {63'd0, d_halt}, 64'd0);

        // Word read at 1021: overflow and misalign.
        apply(1'b1, 1'b0, 2'b11, 32'd1021, 1'b0);
        check("w1021_ovf",  {63'd0, d_ovf}, 64'd1);
        check("w1021_mis",  {63'd0, d_mis}, 64'd1);
        check("w1021_rd",   {63'd0, d_rd}, 64'd0);
        check("w1021_pre_halt", {63'd0, d_halt}, 64'd0);
        tick;
        check("f1_halt",  {63'd0, d_halt}, 64'd1);
        check("f1_addr",  {32'd0, d_faddr}, 64'd1021);
        check("f1_type",  {62'd0, d_ftype}, 64'd3);
        check("f1_num",   {62'd0, d_fnum}, 64'd3);
        check("f1_cnt",   {56'd0, d_cnt}, 64'd1);

        // In FAULT: a valid byte read is blocked, capture holds.
        apply(1'b1, 1'b0, 2'b01, 32'd4, 1'b0);
        check("flt_byte_rd",  {63'd0, d_rd}, 64'd0);
        check("flt_byte_ovf", {63'd0, d_ovf}, 64'd0);
        tick;
        check("flt_addr_hold", {32'd0, d_faddr}, 64'd1021);

        // In FAULT: wrapping word write still flags, no capture, no count.
        apply(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b0);
        check("wrap_ovf", {63'd0, d_ovf}, 64'd1);
        check("wrap_mis", {63'd0, d_mis}, 64'd0);
        check("wrap_wr",  {63'd0, d_wr}, 64'd0);
        tick;
        check("flt_cnt_hold",  {56'd0, d_cnt}, 64'd1);
        check("flt_addr_hold2", {32'd0, d_faddr}, 64'd1021);

        // Clear with a simultaneous bad half write at 1023; clear wins.
        apply(1'b0, 1'b1, 2'b10, 32'd1023, 1'b1);
        check("h1023_ovf", {63'd0, d_ovf}, 64'd1);
        check("h1023_mis", {63'd0, d_mis}, 64'd1);
        check("h1023_wr",  {63'd0, d_wr}, 64'd0);
        check("nal_h1023_ovf", {63'd0, n_ovf}, 64'd1);
        check("nal_h1023_mis", {63'd0, n_mis}, 64'd0);
        tick;
        check("clr_halt", {63'd0, d_halt}, 64'd0);
        check("clr_type", {62'd0, d_ftype}, 64'd0);
        check("clr_addr", {32'd0, d_faddr}, 64'd0);
        check("clr_cnt",  {56'd0, d_cnt}, 64'd1);

        // Clean half write at 1022.
        apply(1'b0, 1'b1, 2'b10, 32'd1022, 1'b0);
        check("h1022_wr",  {63'd0, d_wr}, 64'd1);
        check("h1022_ovf", {63'd0, d_ovf}, 64'd0);
        check("h1022_mis", {63'd0, d_mis}, 64'd0);
        tick;

        // err_clr_i in RUN does nothing.
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        tick;
        check("run_clr_halt", {63'd0, d_halt}, 64'd0);
        check("run_clr_cnt",  {56'd0, d_cnt}, 64'd1);

        // Wrapping word write in RUN: captured as overflow only.
        apply(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b0);
        check("wrap2_wr", {63'd0, d_wr}, 64'd0);
        tick;
        check("f2_halt", {63'd0, d_halt}, 64'd1);
        check("f2_addr", {32'd0, d_faddr}, 64'hFFFF_FFFC);
        check("f2_type", {62'd0, d_ftype}, 64'd2);
        check("f2_cnt",  {56'd0, d_cnt}, 64'd2);
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        tick;

        // Invalid size.
        apply(1'b1, 1'b0, 2'b00, 32'd8, 1'b0);
        check("inv_ovf", {63'd0, d_ovf}, 64'd1);
        check("inv_mis", {63'd0, d_mis}, 64'd1);
        check("inv_rd",  {63'd0, d_rd}, 64'd0);
        tick;
        check("f3_num",  {62'd0, d_fnum}, 64'd0);
        check("f3_type", {62'd0, d_ftype}, 64'd3);
        check("f3_addr", {32'd0, d_faddr}, 64'd8);
        check("f3_cnt",  {56'd0, d_cnt}, 64'd3);
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        tick;

        // Misalign only: word read at 2.
        apply(1'b1, 1'b0, 2'b11, 32'd2, 1'b0);
        check("w2_ovf", {63'd0, d_ovf}, 64'd0);
        check("w2_mis", {63'd0, d_mis}, 64'd1);
        check("nal_w2_rd", {63'd0, n_rd}, 64'd1);
        tick;
        check("f4_type", {62'd0, d_ftype}, 64'd1);
        check("f4_cnt",  {56'd0, d_cnt}, 64'd4);
        check("nal_w2_halt", {63'd0, n_halt}, 64'd0);
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        tick;

        // Counter saturation on the 2-bit instance, from a fresh reset.
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        check("c2_rst_cnt", {62'd0, c_cnt}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            apply(1'b1, 1'b0, 2'b11, 32'd1021, 1'b0);
            tick;
            check($sformatf("c2_cnt_%0d", i), {62'd0, c_cnt}, {62'd0, exp_cnt});
            apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
            tick;
        end

        // Reset while halted, with err_clr_i also high.
        apply(1'b1, 1'b0, 2'b11, 32'd1021, 1'b0);
        tick;
        check("c2_pre_rst_halt", {63'd0, c_halt}, 64'd1);
        rst_i = 1'b1;
        apply(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        tick;
        check("c2_rst_halt",  {63'd0, c_halt}, 64'd0);
        check("c2_rst_cnt2",  {62'd0, c_cnt}, 64'd0);
        check("c2_rst_addr",  {32'd0, c_faddr}, 64'd0);
        check("c2_rst_type",  {62'd0, c_ftype}, 64'd0);
        check("c2_rst_num",   {62'd0, c_fnum}, 64'd0);
        check("c2_rst_rd",    {63'd0, c_rd}, 64'd0);
        rst_i = 1'b0;
        err_clr_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
